debounce_scan_ctrl: RTL and testbench

//  Time-multiplexed debounce controller for the board's push-buttons/switches feeding the

---
 rtl/debounce_scan_ctrl_pkg.sv | 15 +
 rtl/debounce_scan_ctrl_if.sv | 29 ++
 rtl/debounce_scan_ctrl_scan_tick_gen.sv | 28 ++
 rtl/debounce_scan_ctrl.sv | 112 +++++++++++
 tb/tb_debounce_scan_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared types for the front-panel debounce scanner.
// FSM encoding and index-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_scan_ctrl_if.sv
// Press/release event handshake bundle.
// Producer drives valid/ch/rise, consumer drives ready.
interface debounce_scan_ctrl_if
  import debounce_pkg::*;
#(
  parameter int NUM_CH = 4
);
  localparam int CH_W = idx_w(NUM_CH);

  logic            o_Evt_Valid;
  logic            i_Evt_Ready;
  logic [CH_W-1:0] o_Evt_Ch;
  logic            o_Evt_Rise;

  modport master (
    output o_Evt_Valid,
    output o_Evt_Ch,
    output o_Evt_Rise,
    input  i_Evt_Ready
  );

  modport slave (
    input  o_Evt_Valid,
    input  o_Evt_Ch,
    input  o_Evt_Rise,
    output i_Evt_Ready
  );

endinterface

// File: rtl/debounce_scan_ctrl_scan_tick_gen.sv
// Scan-rate prescaler: one-cycle tick on each wrap.
// Count freezes while enable is low.
module scan_tick_gen #(
  parameter int TICK_DIV = 2500
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Enable,
  output logic o_Tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign o_Tick = i_Enable && (cnt == LAST);

  // Advance 0..TICK_DIV-1 only while scanning is enabled.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (i_Enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debounce engine for front-panel inputs.
// One shared evaluator, per-channel counts, handshaked events.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int TICK_DIV     = 2500,
  parameter int STABLE_LIMIT = 25
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Enable,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Level,
  debounce_scan_ctrl_if.master evt,
  output logic              o_Tick_Miss,
  input  logic              i_Miss_Clr
);
  localparam int CH_W  = idx_w(NUM_CH);
  localparam int CNT_W = $clog2(STABLE_LIMIT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t            LIM_M1 = cnt_t'(STABLE_LIMIT - 1);
  localparam logic [CH_W-1:0] IDX_LAST = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  cnt_t              cnt [NUM_CH];
  logic [CH_W-1:0]   idx;
  logic [CH_W-1:0]   idx_nxt;
  state_t            state;
  logic              tick;
  logic              cur_sw;
  logic              cur_lvl;
  cnt_t              cur_cnt;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Enable (i_Enable),
    .o_Tick   (tick)
  );

  assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign cur_sw  = sync2[idx];
  assign cur_lvl = o_Level[idx];
  assign cur_cnt = cnt[idx];

  // Two-flop synchronizer on every raw input.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_Switch;
      sync2 <= sync1;
    end
  end

  // Scan FSM: visit one channel per tick, emit commits as events.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state           <= ST_IDLE;
      idx             <= '0;
      o_Level         <= '0;
      o_Tick_Miss     <= 1'b0;
      evt.o_Evt_Valid <= 1'b0;
      evt.o_Evt_Ch    <= '0;
      evt.o_Evt_Rise  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      if (tick && state != ST_IDLE) o_Tick_Miss <= 1'b1;
      else if (i_Miss_Clr)          o_Tick_Miss <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (tick) state <= ST_EVAL;
        end
        ST_EVAL: begin
          if (cur_sw == cur_lvl) begin
            cnt[idx] <= '0;
            idx      <= idx_nxt;
            state    <= ST_IDLE;
          end else if (cur_cnt != LIM_M1) begin
            cnt[idx] <= cur_cnt + 1'b1;
            idx      <= idx_nxt;
            state    <= ST_IDLE;
          end else begin
            cnt[idx]        <= '0;
            o_Level[idx]    <= cur_sw;
            evt.o_Evt_Valid <= 1'b1;
            evt.o_Evt_Ch    <= idx;
            evt.o_Evt_Rise  <= cur_sw;
            state           <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (evt.i_Evt_Ready) begin
            evt.o_Evt_Valid <= 1'b0;
            idx             <= idx_nxt;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl.
// Edge numbers count posedges since reset release.
module tb_debounce_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] sw;
  logic [3:0] lvl;
  logic       miss;
  logic       clr;

  int checks  = 0;
  int errors  = 0;
  int ecnt    = 0;
  int evt_cnt = 0;

  debounce_scan_ctrl_if #(.NUM_CH(4)) evt_if ();

  debounce_scan_ctrl #(
    .NUM_CH       (4),
    .TICK_DIV     (4),
    .STABLE_LIMIT (3)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Enable    (en),
    .i_Switch    (sw),
    .o_Level     (lvl),
    .evt         (evt_if),
    .o_Tick_Miss (miss),
    .i_Miss_Clr  (clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  always @(posedge clk) begin
    if (rst_n && evt_if.o_Evt_Valid && evt_if.i_Evt_Ready)
      evt_cnt <= evt_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_edge(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic chk_evt(input string tag, input logic v,
                         input logic [1:0] c, input logic r);
    chk({tag, "_valid"}, 32'(evt_if.o_Evt_Valid), 32'(v));
    chk({tag, "_ch"}, 32'(evt_if.o_Evt_Ch), 32'(c));
    chk({tag, "_rise"}, 32'(evt_if.o_Evt_Rise), 32'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog ecnt=%0d", ecnt);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    sw    = 4'hF;
    clr   = 1'b0;
    evt_if.i_Evt_Ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_lvl", 32'(lvl), 32'h0);
    chk("rst_miss", 32'(miss), 32'h0);
    chk_evt("rst", 1'b0, 2'd0, 1'b0);

    sw    = 4'b0100;
    rst_n = 1'b1;
    to_edge(44);
    chk("press_early_lvl", 32'(lvl), 32'h0);
    chk("press_early_valid", 32'(evt_if.o_Evt_Valid), 32'h0);
    to_edge(45);
    chk("press_lvl", 32'(lvl), 32'h4);
    chk_evt("press", 1'b1, 2'd2, 1'b1);
    to_edge(46);
    chk("press_done_valid", 32'(evt_if.o_Evt_Valid), 32'h0);
    chk("press_cnt", 32'(evt_cnt), 32'd1);

    to_edge(49); sw[1] = 1'b1;
    to_edge(63); sw[0] = 1'b1;
    to_edge(75); sw[0] = 1'b0;
    to_edge(81); sw[1] = 1'b0;
    to_edge(97); sw[1] = 1'b1;
    to_edge(136);
    chk("bounce_early_lvl", 32'(lvl), 32'h4);
    chk("bounce_early_valid", 32'(evt_if.o_Evt_Valid), 32'h0);
    to_edge(137);
    chk("bounce_lvl", 32'(lvl), 32'h6);
    chk_evt("bounce", 1'b1, 2'd1, 1'b1);
    to_edge(138);
    chk("bounce_cnt", 32'(evt_cnt), 32'd2);
    sw[3] = 1'b1;

    to_edge(140); evt_if.i_Evt_Ready = 1'b0;
    to_edge(176);
    chk("bp_pre_miss", 32'(miss), 32'h0);
    chk("bp_pre_valid", 32'(evt_if.o_Evt_Valid), 32'h0);
    to_edge(177);
    chk("bp_lvl", 32'(lvl), 32'hE);
    chk_evt("bp_start", 1'b1, 2'd3, 1'b1);
    to_edge(197);
    chk_evt("bp_hold", 1'b1, 2'd3, 1'b1);
    chk("bp_miss", 32'(miss), 32'h1);
    chk("bp_hold_cnt", 32'(evt_cnt), 32'd2);
    evt_if.i_Evt_Ready = 1'b1;
    to_edge(198);
    chk("bp_done_valid", 32'(evt_if.o_Evt_Valid), 32'h0);
    chk("bp_done_cnt", 32'(evt_cnt), 32'd3);
    chk("bp_miss_sticky", 32'(miss), 32'h1);
    to_edge(199); clr = 1'b1;
    to_edge(200);
    chk("miss_clr", 32'(miss), 32'h0);
    clr = 1'b0;

    to_edge(202); sw[3] = 1'b0;
    to_edge(206); sw[0] = 1'b1;
    to_edge(245);
    chk("rel_lvl", 32'(lvl), 32'h6);
    chk_evt("rel", 1'b1, 2'd3, 1'b0);
    to_edge(246);
    chk("rel_cnt", 32'(evt_cnt), 32'd4);
    to_edge(247); evt_if.i_Evt_Ready = 1'b0;
    to_edge(248);
    chk("wrap_pre_valid", 32'(evt_if.o_Evt_Valid), 32'h0);
    to_edge(249);
    chk("wrap_lvl", 32'(lvl), 32'h7);
    chk_evt("wrap", 1'b1, 2'd0, 1'b1);

    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_lvl", 32'(lvl), 32'h0);
    chk_evt("mid_rst", 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    evt_if.i_Evt_Ready = 1'b1;
    rst_n = 1'b1;
    to_edge(36);
    chk("no_replay_valid", 32'(evt_if.o_Evt_Valid), 32'h0);
    chk("no_replay_lvl", 32'(lvl), 32'h0);
    chk("no_replay_cnt", 32'(evt_cnt), 32'd4);
    to_edge(37);
    chk("recommit_lvl", 32'(lvl), 32'h1);
    chk_evt("recommit", 1'b1, 2'd0, 1'b1);
    to_edge(38);
    chk("recommit_cnt", 32'(evt_cnt), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
